// File: rtl/fp_pkg.sv
// Shared FP32 constants and scheduler state encoding.
`default_nettype none

package fp_pkg;
  localparam int         FP32_W       = 32;
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;
  localparam int         NUM_REQ_DEF  = 4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/floating_point_cla.sv
// Combinational FP32 adder: align, add/subtract magnitudes, normalise, truncate.
`default_nettype none

module floating_point_cla
  import fp_pkg::*;
#(
  parameter int N = FP32_W
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);

  logic        a_big, sl, ss, a_nan, b_nan, a_inf, b_inf;
  logic [7:0]  el, es, d;
  logic [22:0] fl, fs;
  logic [27:0] wl, ws, wr;
  logic [8:0]  er;
  logic [4:0]  lz;

  always_comb begin
    a_nan = (a[30:23] == EXP_ALL_ONES) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == EXP_ALL_ONES) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == EXP_ALL_ONES) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == EXP_ALL_ONES) && (b[22:0] == 23'd0);

    // Larger magnitude goes to the "l" side so subtraction never goes negative.
    a_big = a[30:0] >= b[30:0];
    sl    = a_big ? a[31]    : b[31];
    ss    = a_big ? b[31]    : a[31];
    el    = a_big ? a[30:23] : b[30:23];
    es    = a_big ? b[30:23] : a[30:23];
    fl    = a_big ? a[22:0]  : b[22:0];
    fs    = a_big ? b[22:0]  : a[22:0];
    d     = el - es;

    wl = {1'b0, el != 8'd0, fl, 3'b000};
    ws = (d > 8'd27) ? 28'd0 : ({1'b0, es != 8'd0, fs, 3'b000} >> d);

    wr  = 28'd0;
    er  = 9'd0;
    lz  = 5'd0;
    sum = '0;

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      sum = {1'b0, EXP_ALL_ONES, 23'h400000};
    end else if (a_inf) begin
      sum = a;
    end else if (b_inf) begin
      sum = b;
    end else if (sl == ss) begin
      wr = wl + ws + {27'd0, cin};
      er = {1'b0, el};
      if (wr[27]) begin
        wr = wr >> 1;
        er = er + 9'd1;
      end
      if (er >= 9'd255) sum = {sl, EXP_ALL_ONES, 23'd0};
      else              sum = {sl, er[7:0], wr[25:3]};
    end else begin
      wr = wl - ws;
      for (int i = 0; i < 27; i++) begin
        if (wr[i]) lz = 5'(26 - i);
      end
      // Exact cancellation yields +0; results below the normal range flush to zero.
      if ((wr == 28'd0) || ({1'b0, el} <= {4'd0, lz})) begin
        sum = '0;
      end else begin
        wr  = wr << lz;
        er  = {1'b0, el} - {4'd0, lz};
        sum = {sl, er[7:0], wr[25:3]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, else lowest request.
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic            hit_hi, hit_lo;
  logic [ID_W-1:0] idx_hi, idx_lo;

  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    // Descending scan: the last hit written is the lowest index in each class.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit_lo = 1'b1;
        idx_lo = ID_W'(i);
        if (ID_W'(i) >= ptr) begin
          hit_hi = 1'b1;
          idx_hi = ID_W'(i);
        end
      end
    end
    any   = hit_lo;
    idx   = hit_hi ? idx_hi : idx_lo;
    grant = hit_lo ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one FP32 adder across NUM_REQ requesters via a 2-stage pipe.
`default_nettype none

module fp_add_scheduler
  import fp_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FP32_W-1:0] req_a,
  input  logic [NUM_REQ*FP32_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_sub,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [FP32_W-1:0]         resp_sum,
  output logic                      resp_exc,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      idle
);

  state_t              state;
  logic                v1, v2;
  logic [FP32_W-1:0]   s1_a, s1_b;
  logic [ID_W-1:0]     s1_id, rr_ptr;
  logic                adv1, adv2, grant_en, take, any;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     win;
  logic [FP32_W-1:0]   a_sel, b_sel, add_sum;
  logic                sub_sel;

  assign adv2     = !v2 || resp_ready;
  assign adv1     = !v1 || adv2;
  assign grant_en = rst_n && (state == RUN) && adv1;
  assign take     = grant_en && any;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign req_ready = grant_en ? grant : '0;

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        a_sel   = req_a[i*FP32_W +: FP32_W];
        b_sel   = req_b[i*FP32_W +: FP32_W];
        sub_sel = req_sub[i];
      end
    end
  end

  floating_point_cla #(.N(FP32_W)) u_add (
    .a   (s1_a),
    .b   (s1_b),
    .cin (1'b0),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      v1         <= 1'b0;
      v2         <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= '0;
      rr_ptr     <= '0;
      resp_sum   <= '0;
      resp_id    <= '0;
      resp_exc   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;

      if (take) begin
        v1     <= 1'b1;
        s1_a   <= a_sel;
        s1_b   <= {b_sel[FP32_W-1] ^ sub_sel, b_sel[FP32_W-2:0]};
        s1_id  <= win;
        rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end else if (adv2) begin
        v1 <= 1'b0;
      end

      if (v1 && adv2) begin
        v2       <= 1'b1;
        resp_sum <= add_sum;
        resp_id  <= s1_id;
        resp_exc <= (add_sum[30:23] == EXP_ALL_ONES);
      end else if (resp_ready) begin
        v2 <= 1'b0;
      end

      case (state)
        RUN: begin
          if (flush) state <= DRAIN;
        end
        DRAIN: begin
          if (!v1 && !v2) begin
            state      <= RUN;
            flush_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign resp_valid = v2;
  assign idle       = (state == RUN) && !v1 && !v2;

endmodule

`default_nettype wire
